// File: rtl/stage3_argmax_classifier.sv
// Argmax classifier for the stage-3 serial class-score stream: tracks max, runner-up
// and winning index per frame, and publishes each decision through a valid/ready register.
module stage3_argmax_classifier #(
  parameter  int NUM_CLASS = 3,
  parameter  int DATA_BW   = 20,
  localparam int IDX_BW    = $clog2(NUM_CLASS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_in_valid,
  input  logic signed [DATA_BW-1:0] i_value,
  input  logic        [IDX_BW-1:0]  i_index,
  output logic                      o_class_valid,
  input  logic                      i_class_ready,
  output logic        [IDX_BW-1:0]  o_class_idx,
  output logic signed [DATA_BW-1:0] o_class_score,
  output logic        [DATA_BW:0]   o_margin,
  output logic                      o_seq_err,
  output logic                      o_overflow,
  output logic                      o_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_CLASS - 1);
  localparam logic signed [DATA_BW-1:0] MOST_NEG = {1'b1, {(DATA_BW-1){1'b0}}};

  logic [0:0]                state, state_next;
  logic signed [DATA_BW-1:0] max_val, second_val;
  logic [IDX_BW-1:0]         max_idx, exp_idx;

  logic signed [DATA_BW-1:0] fold_max, fold_second;
  logic [IDX_BW-1:0]         fold_idx;
  logic [DATA_BW:0]          fold_margin;
  logic                      start, accept, frame_done, seq_err_next;

  // Strict compare so the earlier (lower) index keeps the win on a tie.
  always_comb begin
    fold_max    = max_val;
    fold_second = second_val;
    fold_idx    = max_idx;
    if (i_value > max_val) begin
      fold_second = max_val;
      fold_max    = i_value;
      fold_idx    = i_index;
    end else if (i_value > second_val) begin
      fold_second = i_value;
    end
    fold_margin = {fold_max[DATA_BW-1], fold_max} - {fold_second[DATA_BW-1], fold_second};
  end

  always_comb begin
    start        = 1'b0;
    accept       = 1'b0;
    seq_err_next = 1'b0;
    state_next   = state;
    case (state)
      IDLE: begin
        if (i_in_valid) begin
          if (i_index == '0) start = 1'b1;
          else               seq_err_next = 1'b1;
        end
      end
      SCAN: begin
        if (!i_in_valid) begin
          seq_err_next = 1'b1;
          state_next   = IDLE;
        end else if (i_index == exp_idx) begin
          accept = 1'b1;
          if (exp_idx == LAST_IDX) state_next = IDLE;
        end else begin
          seq_err_next = 1'b1;
          if (i_index == '0) start = 1'b1;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) state_next = SCAN;
  end

  assign frame_done = accept && (exp_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      max_val    <= '0;
      second_val <= '0;
      max_idx    <= '0;
      exp_idx    <= '0;
      o_seq_err  <= 1'b0;
    end else begin
      state     <= state_next;
      o_seq_err <= seq_err_next;
      if (start) begin
        max_val    <= i_value;
        second_val <= MOST_NEG;
        max_idx    <= '0;
        exp_idx    <= IDX_BW'(1);
      end else if (accept) begin
        max_val    <= fold_max;
        second_val <= fold_second;
        max_idx    <= fold_idx;
        exp_idx    <= frame_done ? '0 : exp_idx + IDX_BW'(1);
      end
    end
  end

  // A finished frame is dropped (not queued) if the previous decision is still unaccepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_class_valid <= 1'b0;
      o_class_idx   <= '0;
      o_class_score <= '0;
      o_margin      <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      if (frame_done) begin
        if (o_class_valid && !i_class_ready) begin
          o_overflow <= 1'b1;
        end else begin
          o_class_valid <= 1'b1;
          o_class_idx   <= fold_idx;
          o_class_score <= fold_max;
          o_margin      <= fold_margin;
        end
      end else if (o_class_valid && i_class_ready) begin
        o_class_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state == SCAN);

endmodule

// File: tb/tb_stage3_argmax_classifier.sv
// Scoreboard bench for stage3_argmax_classifier: directed frames push expected decisions,
// a negedge monitor pops and compares on every valid&ready handshake.
`timescale 1ns/1ps
module tb_stage3_argmax_classifier;

  localparam int NUM_CLASS = 3;
  localparam int DATA_BW   = 20;
  localparam int IDX_BW    = 2;

  typedef struct packed {
    logic [IDX_BW-1:0]         idx;
    logic signed [DATA_BW-1:0] score;
    logic [DATA_BW:0]          margin;
  } result_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic signed [DATA_BW-1:0] value;
  logic [IDX_BW-1:0]         index;
  logic                      class_valid;
  logic                      class_ready;
  logic [IDX_BW-1:0]         class_idx;
  logic signed [DATA_BW-1:0] class_score;
  logic [DATA_BW:0]          margin;
  logic                      seq_err;
  logic                      overflow;
  logic                      busy;

  result_t exp_q[$];
  result_t mon_exp;
  int checks = 0;
  int errors = 0;
  int seq_err_count = 0;
  int overflow_count = 0;
  int seq_base;

  stage3_argmax_classifier #(.NUM_CLASS(NUM_CLASS), .DATA_BW(DATA_BW)) dut (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_value(value), .i_index(index),
    .o_class_valid(class_valid), .i_class_ready(class_ready), .o_class_idx(class_idx),
    .o_class_score(class_score), .o_margin(margin), .o_seq_err(seq_err),
    .o_overflow(overflow), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic signed [DATA_BW-1:0] v, input logic [IDX_BW-1:0] i);
    in_valid = 1'b1;
    value    = v;
    index    = i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input logic push,
                            input int e_idx, input int e_score, input int e_margin);
    result_t r;
    if (push) begin
      r.idx    = IDX_BW'(e_idx);
      r.score  = DATA_BW'(e_score);
      r.margin = (DATA_BW+1)'(e_margin);
      exp_q.push_back(r);
    end
    apply_stimulus(DATA_BW'(a), 2'd0);
    apply_stimulus(DATA_BW'(b), 2'd1);
    apply_stimulus(DATA_BW'(c), 2'd2);
  endtask

  // Monitor: counts pulses and checks every accepted decision against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (seq_err)  seq_err_count++;
      if (overflow) overflow_count++;
      if (class_valid && class_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got idx %0d score %0d, expected none",
                   class_idx, class_score);
        end else begin
          mon_exp = exp_q.pop_front();
          check_output("result_idx", 32'(class_idx), 32'(mon_exp.idx));
          check_output("result_score", 32'(class_score), 32'(mon_exp.score));
          check_output("result_margin", 32'(margin), 32'(mon_exp.margin));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    value       = '0;
    index       = '0;
    class_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", 32'(class_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_margin", 32'(margin), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // Basic frame with explicit latency checks.
    exp_q.push_back('{idx: 2'd2, score: 20'sd12, margin: 21'd7});
    apply_stimulus(20'sd5, 2'd0);
    check_output("busy_in_scan", 32'(busy), 32'd1);
    apply_stimulus(-20'sd3, 2'd1);
    check_output("no_early_valid", 32'(class_valid), 32'd0);
    apply_stimulus(20'sd12, 2'd2);
    check_output("latency_valid", 32'(class_valid), 32'd1);
    check_output("idle_after_last", 32'(busy), 32'd0);

    // Back-to-back frames: tie, near-full range, and full DATA_BW+1 margin.
    send_frame(-8, -8, -20, 1'b1, 0, -8, 0);
    send_frame(524287, -524288, 0, 1'b1, 0, 524287, 524287);
    send_frame(524287, -524288, -524288, 1'b1, 0, 524287, 1048575);
    idle_cycles(3);

    // Held output while the consumer stalls; the second frame is dropped.
    class_ready = 1'b0;
    send_frame(1, 2, 3, 1'b1, 2, 3, 1);
    send_frame(10, 0, 0, 1'b0, 0, 0, 0);
    idle_cycles(3);
    check_output("overflow_once", 32'(overflow_count), 32'd1);
    check_output("held_valid", 32'(class_valid), 32'd1);
    check_output("held_idx", 32'(class_idx), 32'd2);
    check_output("held_score", 32'(class_score), 32'd3);
    check_output("held_margin", 32'(margin), 32'd1);
    class_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("valid_drops", 32'(class_valid), 32'd0);
    idle_cycles(2);

    // Sequence errors.
    seq_base = seq_err_count;
    apply_stimulus(20'sd1, 2'd0);
    apply_stimulus(20'sd2, 2'd2);
    idle_cycles(2);
    check_output("seq_skip_err", 32'(seq_err_count - seq_base), 32'd1);
    check_output("seq_skip_no_result", 32'(class_valid), 32'd0);
    check_output("seq_skip_idle", 32'(busy), 32'd0);

    seq_base = seq_err_count;
    apply_stimulus(20'sd1, 2'd0);
    apply_stimulus(20'sd1, 2'd1);
    idle_cycles(2);
    check_output("seq_gap_err", 32'(seq_err_count - seq_base), 32'd1);
    check_output("seq_gap_idle", 32'(busy), 32'd0);

    seq_base = seq_err_count;
    exp_q.push_back('{idx: 2'd1, score: 20'sd9, margin: 21'd3});
    apply_stimulus(20'sd100, 2'd0);
    apply_stimulus(20'sd4, 2'd0);
    check_output("restart_busy", 32'(busy), 32'd1);
    apply_stimulus(20'sd9, 2'd1);
    apply_stimulus(20'sd6, 2'd2);
    idle_cycles(2);
    check_output("seq_restart_err", 32'(seq_err_count - seq_base), 32'd1);

    // Asynchronous reset mid-frame while a decision is held.
    class_ready = 1'b0;
    send_frame(1, 2, 3, 1'b0, 0, 0, 0);
    apply_stimulus(20'sd3, 2'd0);
    apply_stimulus(20'sd4, 2'd1);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_output("async_reset_valid", 32'(class_valid), 32'd0);
    check_output("async_reset_busy", 32'(busy), 32'd0);
    check_output("async_reset_score", 32'(class_score), 32'd0);
    check_output("async_reset_idx", 32'(class_idx), 32'd0);
    class_ready = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    seq_base = seq_err_count;
    idle_cycles(1);
    send_frame(7, -1, -2, 1'b1, 0, 7, 8);
    idle_cycles(3);
    check_output("post_reset_seq_err", 32'(seq_err_count - seq_base), 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
